// File: rtl/stream_demux_1_to_2_fifo_2_entry.sv
// Two-entry FIFO with a separate occupancy counter and zero-filled head when empty.
// Used once per output side of stream_demux_1_to_2.
module fifo_2_entry #(
  parameter int unsigned bits = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic [bits-1:0] push_data,
  input  logic            pop,
  output logic [bits-1:0] head,
  output logic            valid,
  output logic [1:0]      count,
  output logic            full
);

  localparam logic [1:0] DEPTH = 2'd2;

  logic [bits-1:0] r_mem [2];
  logic            r_rd_ptr;
  logic            r_wr_ptr;
  logic [1:0]      r_count;
  logic            w_push;
  logic            w_pop;

  // Guard both sides so a stray pop on empty or push on full leaves state untouched.
  assign w_push = push & (r_count != DEPTH);
  assign w_pop  = pop & (r_count != 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign valid = (r_count != 2'd0);
  assign full  = (r_count == DEPTH);
  assign count = r_count;
  assign head  = valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/stream_demux_1_to_2.sv
// Buffered 1-to-2 stream demux: each beat is steered by select into the X or Y
// two-entry FIFO; a stall on one side never blocks the other.
module stream_demux_1_to_2 #(
  parameter int unsigned bits = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [bits-1:0] in,
  input  logic            select,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [bits-1:0] out_x,
  output logic            x_valid,
  input  logic            x_ready,
  output logic [bits-1:0] out_y,
  output logic            y_valid,
  input  logic            y_ready,
  output logic [1:0]      x_count,
  output logic [1:0]      y_count
);

  logic w_accept;
  logic w_push_x;
  logic w_push_y;
  logic w_full_x;
  logic w_full_y;

  // Ready is a function of select and registered occupancy only.
  assign in_ready = select ? (y_count != 2'd2) : (x_count != 2'd2);
  assign w_accept = in_valid & in_ready;
  assign w_push_x = w_accept & ~select;
  assign w_push_y = w_accept & select;

  fifo_2_entry #(.bits(bits)) u_fifo_x (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push_x),
    .push_data (in),
    .pop       (x_ready),
    .head      (out_x),
    .valid     (x_valid),
    .count     (x_count),
    .full      (w_full_x)
  );

  fifo_2_entry #(.bits(bits)) u_fifo_y (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push_y),
    .push_data (in),
    .pop       (y_ready),
    .head      (out_y),
    .valid     (y_valid),
    .count     (y_count),
    .full      (w_full_y)
  );

  logic w_unused;
  assign w_unused = w_full_x ^ w_full_y;

endmodule

// File: tb/tb_stream_demux_1_to_2.sv
// Directed self-checking bench for stream_demux_1_to_2.
module tb_stream_demux_1_to_2;

  logic        clk;
  logic        reset_n;
  logic [15:0] in;
  logic        select;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_x;
  logic        x_valid;
  logic        x_ready;
  logic [15:0] out_y;
  logic        y_valid;
  logic        y_ready;
  logic [1:0]  x_count;
  logic [1:0]  y_count;

  int unsigned errs;
  int unsigned checks;

  stream_demux_1_to_2 #(.bits(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in       (in),
    .select   (select),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_x    (out_x),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .out_y    (out_y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .x_count  (x_count),
    .y_count  (y_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errs     = 0;
    checks   = 0;
    reset_n  = 1'b0;
    in       = '0;
    select   = 1'b0;
    in_valid = 1'b0;
    x_ready  = 1'b0;
    y_ready  = 1'b0;
    tick();
    check("rst_x_count", 32'(x_count), 0);
    check("rst_y_count", 32'(y_count), 0);
    check("rst_x_valid", 32'(x_valid), 0);
    check("rst_y_valid", 32'(y_valid), 0);
    check("rst_out_x", 32'(out_x), 0);
    check("rst_out_y", 32'(out_y), 0);
    reset_n = 1'b1;
    tick();

    // Reset mid-stream
    in = 16'h1111; select = 1'b0; in_valid = 1'b1;
    tick();
    in = 16'h2222;
    tick();
    in_valid = 1'b0;
    check("mid_fill_count", 32'(x_count), 2);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(x_count), 0);
    check("mid_rst_valid", 32'(x_valid), 0);
    check("mid_rst_out", 32'(out_x), 0);
    #1 reset_n = 1'b1;
    tick();
    in = 16'h3333; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_out", 32'(out_x), 32'h3333);
    check("post_rst_count", 32'(x_count), 1);
    x_ready = 1'b1;
    tick();
    x_ready = 1'b0;
    check("post_rst_alone", 32'(x_count), 0);
    check("post_rst_empty_out", 32'(out_x), 0);

    // Routing
    in = 16'hAAAA; select = 1'b0; in_valid = 1'b1;
    tick();
    in = 16'h5555; select = 1'b1;
    #1;
    check("route_y_before", 32'(out_y), 0);
    check("route_yv_before", 32'(y_valid), 0);
    check("route_x_early", 32'(out_x), 32'hAAAA);
    tick();
    in_valid = 1'b0;
    check("route_out_x", 32'(out_x), 32'hAAAA);
    check("route_out_y", 32'(out_y), 32'h5555);
    check("route_x_count", 32'(x_count), 1);
    check("route_y_count", 32'(y_count), 1);
    x_ready = 1'b1; y_ready = 1'b1;
    tick();
    x_ready = 1'b0; y_ready = 1'b0;
    check("route_drain_x", 32'(x_count), 0);
    check("route_drain_y", 32'(y_count), 0);

    // Full and independence
    in = 16'h0001; select = 1'b0; in_valid = 1'b1;
    #1;
    check("full_rdy0", 32'(in_ready), 1);
    tick();
    in = 16'h0002;
    tick();
    in = 16'h0003;
    #1;
    check("full_rdy_drop", 32'(in_ready), 0);
    check("full_count", 32'(x_count), 2);
    tick();
    check("full_stall_count", 32'(x_count), 2);
    check("full_stall_head", 32'(out_x), 32'h0001);
    in = 16'h00FF; select = 1'b1;
    #1;
    check("indep_rdy", 32'(in_ready), 1);
    tick();
    check("indep_y_count", 32'(y_count), 1);
    check("indep_out_y", 32'(out_y), 32'h00FF);
    check("indep_x_count", 32'(x_count), 2);
    in = 16'h0003; select = 1'b0; x_ready = 1'b1;
    tick();
    check("drain1_head", 32'(out_x), 32'h0002);
    check("drain1_count", 32'(x_count), 1);
    check("drain1_rdy", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("drain2_head", 32'(out_x), 32'h0003);
    check("drain2_count", 32'(x_count), 1);
    y_ready = 1'b1;
    tick();
    x_ready = 1'b0; y_ready = 1'b0;
    check("drain3_x_count", 32'(x_count), 0);
    check("drain3_out_x", 32'(out_x), 0);
    check("drain3_y_count", 32'(y_count), 0);

    // Simultaneous push and pop at count=1
    in = 16'h0010; select = 1'b0; in_valid = 1'b1;
    tick();
    check("pp_setup", 32'(out_x), 32'h0010);
    in = 16'h0020; x_ready = 1'b1;
    tick();
    in_valid = 1'b0; x_ready = 1'b0;
    check("pp_count", 32'(x_count), 1);
    check("pp_head", 32'(out_x), 32'h0020);
    x_ready = 1'b1;
    tick();
    x_ready = 1'b0;
    check("pp_empty", 32'(x_count), 0);

    // Wrap-around streaming
    x_ready = 1'b1; select = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in = 16'(i);
      tick();
      check("stream_head", 32'(out_x), 32'(i));
      check("stream_count", 32'(x_count), 1);
    end
    in_valid = 1'b0;
    tick();
    x_ready = 1'b0;
    check("stream_end_count", 32'(x_count), 0);

    // Illegal pops on empty FIFOs
    x_ready = 1'b1; y_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ill_x_count", 32'(x_count), 0);
      check("ill_y_count", 32'(y_count), 0);
      check("ill_valids", 32'({x_valid, y_valid}), 0);
      check("ill_outs", {out_x, out_y}, 0);
    end
    x_ready = 1'b0; y_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
